// File: rtl/cnn_pkg.sv
// Shared constants, layer codes and sequencer state encoding for the
// conv/pool/flatten address path.
package cnn_pkg;

  localparam int CNN_IMG_W  = 64;
  localparam int CNN_ADDR_W = 12;

  typedef enum logic [1:0] {
    L_CONV = 2'd0,
    L_POOL = 2'd1,
    L_FLAT = 2'd2,
    L_ILL  = 2'd3
  } layer_e;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_TAP  = 2'd1;
  localparam state_t S_WR   = 2'd2;
  localparam state_t S_DONE = 2'd3;

endpackage

// File: rtl/tap_offset_lut.sv
// Window tap geometry: (layer, tap) -> signed row/col offset and last-tap flag.
// Offsets are 2-bit two's complement (-1..+1).
module tap_offset_lut
  import cnn_pkg::*;
(
  input  logic [1:0] layer,
  input  logic [3:0] tap_idx,
  output logic [1:0] dy,
  output logic [1:0] dx,
  output logic       last_tap
);

  // conv walks a 3x3 window around the centre, pool a 2x2 from top-left,
  // flatten has a single tap at offset 0
  always_comb begin
    dy       = 2'b00;
    dx       = 2'b00;
    last_tap = 1'b1;
    case (layer)
      L_CONV: begin
        last_tap = (tap_idx == 4'd8);
        case (tap_idx)
          4'd0, 4'd1, 4'd2: dy = 2'b11;
          4'd6, 4'd7, 4'd8: dy = 2'b01;
          default:          dy = 2'b00;
        endcase
        case (tap_idx)
          4'd0, 4'd3, 4'd6: dx = 2'b11;
          4'd2, 4'd5, 4'd8: dx = 2'b01;
          default:          dx = 2'b00;
        endcase
      end
      L_POOL: begin
        last_tap = (tap_idx == 4'd3);
        dy       = {1'b0, tap_idx[1]};
        dx       = {1'b0, tap_idx[0]};
      end
      default: last_tap = 1'b1;
    endcase
  end

endmodule

// File: rtl/win_addr_seq.sv
// Per-layer address sequencer. Walks output pixels in raster order, one read
// tap per cycle followed by one write slot. All outputs are registered from
// the next-state values; only rd_vld/wr_en see hold combinationally.
module win_addr_seq
  import cnn_pkg::*;
#(
  parameter int IMG_W  = CNN_IMG_W,
  parameter int ADDR_W = CNN_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        layer,
  input  logic              hold,
  output logic              busy,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_vld,
  output logic              rd_pad,
  output logic [3:0]        tap_idx,
  output logic              fm_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              done
);

  localparam int            LW        = $clog2(IMG_W);
  localparam logic [LW-1:0] CONV_LAST = LW'(IMG_W - 1);
  localparam logic [LW-1:0] HALF_LAST = LW'(IMG_W / 2 - 1);

  state_t        state_q, state_n;
  logic [1:0]    layer_q, layer_n;
  logic [LW-1:0] row_q, row_n, col_q, col_n;
  logic [3:0]    tap_q, tap_n;
  logic          fm_q, fm_n;
  logic          last_q;
  logic [LW-1:0] ext_last;
  logic          rc_last;

  logic [1:0]    dy, dx;
  logic          lut_last;
  logic [LW:0]   rs, cs;

  logic              busy_n, done_n, rd_vld_n, rd_pad_n, fm_o_n, wr_en_n;
  logic [ADDR_W-1:0] rd_addr_n, wr_addr_n;
  logic [3:0]        tap_o_n;
  logic              rd_vld_q, wr_en_q;

  // geometry for the slot about to be presented
  tap_offset_lut u_lut (
    .layer    (layer_n),
    .tap_idx  (tap_n),
    .dy       (dy),
    .dx       (dx),
    .last_tap (lut_last)
  );

  assign ext_last = (layer_q == L_CONV) ? CONV_LAST : HALF_LAST;
  assign rc_last  = (row_q == ext_last) && (col_q == ext_last);

  // FSM and raster counters; hold freezes everything while busy
  always_comb begin
    state_n = state_q;
    layer_n = layer_q;
    row_n   = row_q;
    col_n   = col_q;
    tap_n   = tap_q;
    fm_n    = fm_q;
    case (state_q)
      S_IDLE: begin
        if (start && (layer != L_ILL)) begin
          state_n = S_TAP;
          layer_n = layer;
          row_n   = '0;
          col_n   = '0;
          tap_n   = '0;
          fm_n    = 1'b0;
        end
      end
      S_TAP: begin
        if (!hold) begin
          if (last_q) begin
            state_n = S_WR;
            tap_n   = '0;
          end else begin
            tap_n = tap_q + 4'd1;
          end
        end
      end
      S_WR: begin
        if (!hold) begin
          if (rc_last && ((layer_q == L_CONV) || fm_q)) begin
            state_n = S_DONE;
          end else begin
            state_n = S_TAP;
            if ((layer_q == L_FLAT) && !fm_q) begin
              // flatten: second map of the same element before moving on
              fm_n = 1'b1;
            end else begin
              if (layer_q == L_FLAT) fm_n = 1'b0;
              if (col_q == ext_last) begin
                col_n = '0;
                if (row_q == ext_last) begin
                  // pool: first map finished, restart raster on map 1
                  row_n = '0;
                  fm_n  = 1'b1;
                end else begin
                  row_n = row_q + LW'(1);
                end
              end else begin
                col_n = col_q + LW'(1);
              end
            end
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // address/flag values for the next slot; conv bounds test on the sign bit
  always_comb begin
    rs        = {1'b0, row_n} + {{(LW-1){dy[1]}}, dy};
    cs        = {1'b0, col_n} + {{(LW-1){dx[1]}}, dx};
    busy_n    = (state_n == S_TAP) || (state_n == S_WR);
    done_n    = (state_n == S_DONE);
    rd_addr_n = '0;
    rd_vld_n  = 1'b0;
    rd_pad_n  = 1'b0;
    tap_o_n   = '0;
    fm_o_n    = 1'b0;
    wr_addr_n = '0;
    wr_en_n   = 1'b0;
    if (state_n == S_TAP) begin
      tap_o_n = tap_n;
      fm_o_n  = fm_n;
      case (layer_n)
        L_CONV: begin
          if (rs[LW] || cs[LW]) begin
            rd_pad_n = 1'b1;
          end else begin
            rd_vld_n  = 1'b1;
            rd_addr_n = ADDR_W'({rs[LW-1:0], cs[LW-1:0]});
          end
        end
        L_POOL: begin
          rd_vld_n  = 1'b1;
          rd_addr_n = ADDR_W'({row_n[LW-2:0], dy[0], col_n[LW-2:0], dx[0]});
        end
        default: begin
          rd_vld_n  = 1'b1;
          rd_addr_n = ADDR_W'({row_n[LW-2:0], col_n[LW-2:0]});
        end
      endcase
    end else if (state_n == S_WR) begin
      wr_en_n = 1'b1;
      fm_o_n  = fm_n;
      case (layer_n)
        L_CONV:  wr_addr_n = ADDR_W'({row_n, col_n});
        L_POOL:  wr_addr_n = ADDR_W'({row_n[LW-2:0], col_n[LW-2:0]});
        default: wr_addr_n = ADDR_W'({row_n[LW-2:0], col_n[LW-2:0], fm_n});
      endcase
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      layer_q  <= 2'd0;
      row_q    <= '0;
      col_q    <= '0;
      tap_q    <= '0;
      fm_q     <= 1'b0;
      last_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_addr  <= '0;
      rd_vld_q <= 1'b0;
      rd_pad   <= 1'b0;
      tap_idx  <= '0;
      fm_sel   <= 1'b0;
      wr_addr  <= '0;
      wr_en_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      layer_q  <= layer_n;
      row_q    <= row_n;
      col_q    <= col_n;
      tap_q    <= tap_n;
      fm_q     <= fm_n;
      last_q   <= lut_last;
      busy     <= busy_n;
      done     <= done_n;
      rd_addr  <= rd_addr_n;
      rd_vld_q <= rd_vld_n;
      rd_pad   <= rd_pad_n;
      tap_idx  <= tap_o_n;
      fm_sel   <= fm_o_n;
      wr_addr  <= wr_addr_n;
      wr_en_q  <= wr_en_n;
    end
  end

  assign rd_vld = rd_vld_q & ~hold;
  assign wr_en  = wr_en_q & ~hold;

endmodule

// File: tb/tb_win_addr_seq.sv
// Bench for win_addr_seq: a slot-list model built from the window rules is
// compared against the DUT every cycle; directed literals pin the model.
module tb_win_addr_seq;

  logic        clk = 1'b0;
  logic        reset, start, hold;
  logic [1:0]  layer;
  logic        busy, rd_vld, rd_pad, fm_sel, wr_en, done;
  logic [11:0] rd_addr, wr_addr;
  logic [3:0]  tap_idx;

  win_addr_seq dut (
    .clk(clk), .reset(reset), .start(start), .layer(layer), .hold(hold),
    .busy(busy), .rd_addr(rd_addr), .rd_vld(rd_vld), .rd_pad(rd_pad),
    .tap_idx(tap_idx), .fm_sel(fm_sel), .wr_addr(wr_addr), .wr_en(wr_en),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; bit vld; bit pad; int ra; int tap; bit fm; int wa; } slot_t;
  typedef struct { string nm; int act; int exp; } lit_t;

  slot_t exp_q[$];
  slot_t cur, e;
  int    ph;          // 0 idle, 1 in pass, 2 done cycle
  bit    chk_en;
  int    n_tests, n_fail;
  lit_t  lit_q[$];
  int    lit_rd;
  int    cn;

  function automatic slot_t mk(bit wr, bit vld, bit pad, int ra, int tap, bit fm, int wa);
    slot_t s;
    s.wr = wr; s.vld = vld; s.pad = pad; s.ra = ra; s.tap = tap; s.fm = fm; s.wa = wa;
    return s;
  endfunction

  // expected slot sequence of a whole pass
  function automatic void build(int l);
    if (l == 0) begin
      for (int r = 0; r < 64; r++)
        for (int c = 0; c < 64; c++) begin
          for (int k = 0; k < 9; k++) begin
            int y = r + k / 3 - 1;
            int x = c + k % 3 - 1;
            if (y < 0 || y > 63 || x < 0 || x > 63) exp_q.push_back(mk(0, 0, 1, 0, k, 0, 0));
            else exp_q.push_back(mk(0, 1, 0, y * 64 + x, k, 0, 0));
          end
          exp_q.push_back(mk(1, 0, 0, 0, 0, 0, r * 64 + c));
        end
    end else if (l == 1) begin
      for (int f = 0; f < 2; f++)
        for (int r = 0; r < 32; r++)
          for (int c = 0; c < 32; c++) begin
            for (int k = 0; k < 4; k++)
              exp_q.push_back(mk(0, 1, 0, (2 * r + k / 2) * 64 + 2 * c + k % 2, k, f[0], 0));
            exp_q.push_back(mk(1, 0, 0, 0, 0, f[0], r * 32 + c));
          end
    end else begin
      for (int i = 0; i < 1024; i++) begin
        exp_q.push_back(mk(0, 1, 0, i, 0, 0, 0));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 2 * i));
        exp_q.push_back(mk(0, 1, 0, i, 0, 1, 0));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 2 * i + 1));
      end
    end
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // compare against the model mid-cycle, then advance the model on the inputs
  always @(negedge clk) begin
    e = (ph == 1) ? cur : mk(0, 0, 0, 0, 0, 0, 0);
    if (chk_en) begin
      chk("busy",    busy,    ph == 1);
      chk("done",    done,    ph == 2);
      chk("rd_vld",  rd_vld,  e.vld && !hold);
      chk("rd_pad",  rd_pad,  e.pad);
      chk("rd_addr", rd_addr, e.ra);
      chk("tap_idx", tap_idx, e.tap);
      chk("fm_sel",  fm_sel,  e.fm);
      chk("wr_en",   wr_en,   e.wr && !hold);
      chk("wr_addr", wr_addr, e.wa);
    end
    while (lit_rd < lit_q.size()) begin
      chk(lit_q[lit_rd].nm, lit_q[lit_rd].act, lit_q[lit_rd].exp);
      lit_rd++;
    end
    if (reset) begin
      ph = 0;
      exp_q.delete();
    end else begin
      case (ph)
        0: if (start && layer != 2'd3) begin
             build(int'(layer));
             cur = exp_q.pop_front();
             ph  = 1;
           end
        1: if (!hold) begin
             if (exp_q.size() == 0) ph = 2;
             else cur = exp_q.pop_front();
           end
        default: ph = 0;
      endcase
    end
  end

  task automatic lit(string nm, int act, int exp);
    lit_t t;
    t.nm = nm; t.act = act; t.exp = exp;
    lit_q.push_back(t);
  endtask

  task automatic cyc();
    @(posedge clk);
    #3;
    cn++;
  endtask

  task automatic wait_to(int n);
    while (cn < n) cyc();
  endtask

  task automatic go(int l);
    layer = 2'(l);
    start = 1'b1;
    cn    = 0;
    cyc();
    start = 1'b0;
  endtask

  logic [8:0] pad00  = 9'h04F;
  logic [8:0] pad63  = 9'h1E4;
  int addr00[9] = '{0, 0, 0, 0, 0, 1, 0, 64, 65};
  int addr63[9] = '{4030, 4031, 0, 4094, 4095, 0, 0, 0, 0};
  int pool12[4] = '{132, 133, 196, 197};
  int ndone;

  initial begin
    reset = 1'b1; start = 1'b0; layer = 2'd0; hold = 1'b0;
    chk_en = 1'b0; ph = 0; n_tests = 0; n_fail = 0; lit_rd = 0; cn = 0;
    @(posedge clk); #3;
    chk_en = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    lit("rst_busy", busy, 0);
    lit("rst_done", done, 0);
    lit("rst_rd_addr", rd_addr, 0);
    lit("rst_wr_en", wr_en, 0);

    // conv pass, with a start/layer change while busy at cycle 100
    go(0);
    for (int k = 0; k < 9; k++) begin
      wait_to(k + 1);
      lit("conv00_tap", tap_idx, k);
      lit("conv00_pad", rd_pad, pad00[k]);
      lit("conv00_addr", rd_addr, addr00[k]);
    end
    wait_to(10);
    lit("conv00_wr_en", wr_en, 1);
    lit("conv00_wr_addr", wr_addr, 0);
    wait_to(100);
    start = 1'b1; layer = 2'd1;
    cyc();
    start = 1'b0; layer = 2'd0;
    lit("busy_start_ignored", busy, 1);
    lit("busy_start_tap", tap_idx, 0);
    for (int k = 0; k < 9; k++) begin
      wait_to(40951 + k);
      lit("conv63_pad", rd_pad, pad63[k]);
      lit("conv63_addr", rd_addr, addr63[k]);
    end
    wait_to(40960);
    lit("conv63_wr_addr", wr_addr, 4095);
    wait_to(40961);
    lit("conv_done", done, 1);
    lit("conv_done_busy", busy, 0);
    cyc();
    lit("conv_done_pulse", done, 0);

    // pool pass
    cyc();
    go(1);
    for (int k = 0; k < 4; k++) begin
      wait_to(171 + k);
      lit("pool12_addr", rd_addr, pool12[k]);
      lit("pool12_fm", fm_sel, 0);
    end
    wait_to(175);
    lit("pool12_wr_addr", wr_addr, 34);
    lit("pool12_wr_en", wr_en, 1);
    wait_to(5121);
    lit("pool_fm1_sel", fm_sel, 1);
    lit("pool_fm1_addr", rd_addr, 0);
    wait_to(10240);
    lit("pool_last_wr", wr_addr, 1023);
    lit("pool_last_busy", busy, 1);
    wait_to(10241);
    lit("pool_done", done, 1);

    // flatten pass
    cyc();
    go(2);
    wait_to(21); lit("flat5_rd0", rd_addr, 5); lit("flat5_fm0", fm_sel, 0);
    wait_to(22); lit("flat5_wr0", wr_addr, 10);
    wait_to(23); lit("flat5_rd1", rd_addr, 5); lit("flat5_fm1", fm_sel, 1);
    wait_to(24); lit("flat5_wr1", wr_addr, 11);
    wait_to(4097);
    lit("flat_done", done, 1);

    // illegal layer is ignored
    cyc(); cyc();
    start = 1'b1; layer = 2'd3;
    cyc();
    start = 1'b0; layer = 2'd0;
    lit("ill_busy", busy, 0);
    cyc();
    lit("ill_busy2", busy, 0);

    // conv pass with a hold at pixel (0,2) tap 3, aborted by reset at cycle 500
    cyc();
    go(0);
    wait_to(24);
    lit("hold_pre_tap", tap_idx, 3);
    hold = 1'b1;
    #1;
    lit("hold_vld_gated", rd_vld, 0);
    cyc();
    lit("hold_tap_frozen", tap_idx, 3);
    lit("hold_addr_frozen", rd_addr, 1);
    cyc();
    cyc();
    hold = 1'b0;
    #1;
    lit("hold_reissue_tap", tap_idx, 3);
    lit("hold_reissue_vld", rd_vld, 1);
    lit("hold_reissue_addr", rd_addr, 1);
    cyc();
    lit("hold_next_tap", tap_idx, 4);
    lit("hold_next_addr", rd_addr, 2);
    wait_to(500);
    reset = 1'b1;
    cyc();
    lit("abort_busy", busy, 0);
    lit("abort_rd_addr", rd_addr, 0);
    lit("abort_tap", tap_idx, 0);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (done) ndone++;
    end
    lit("abort_no_done", ndone, 0);

    cyc();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
